// File: rtl/mtr_ramp.sv
// Dual-channel motor speed slew limiter with IDLE/RAMP/SETTLED/STOP control.
// Define RAMP_ZERO_CROSS_HOLD_EN to clamp sign reversals to zero with a one-tick dwell.
module mtr_ramp #(
    parameter int STEP = 8,
    parameter int DIV  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               estop,
    input  logic signed [10:0] tgt_lft,
    input  logic signed [10:0] tgt_rght,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd,
    output logic               settled,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RAMP, SETTLED, STOP} state_t;

    localparam logic signed [11:0] STEP1 = 12'(STEP);
    localparam logic signed [11:0] STEP4 = 12'(4 * STEP);

    state_t             state, state_nxt;
    logic        [15:0] cnt;
    logic               tick;
    logic signed [11:0] step_sel;
    logic signed [10:0] aim_l, aim_r, cand_l, cand_r, lft_nxt, rght_nxt;

    assign tick = (state != IDLE) && (cnt == 16'(DIV - 1));

    // Move cur toward tgt by at most step; 12-bit math keeps the difference exact.
    function automatic logic signed [10:0] slew(input logic signed [10:0] cur,
                                                input logic signed [10:0] tgt,
                                                input logic signed [11:0] step);
        logic signed [11:0] diff, mag, nxt;
        diff = {tgt[10], tgt} - {cur[10], cur};
        mag  = diff[11] ? -diff : diff;
        if (mag <= step)   nxt = {tgt[10], tgt};
        else if (diff[11]) nxt = {cur[10], cur} - step;
        else               nxt = {cur[10], cur} + step;
        return nxt[10:0];
    endfunction

`ifdef RAMP_ZERO_CROSS_HOLD_EN
    logic hold_l, hold_r, hold_l_nxt, hold_r_nxt;

    function automatic logic crosses(input logic signed [10:0] cur,
                                     input logic signed [10:0] nxt);
        return (cur != '0) && (nxt != '0) && (cur[10] != nxt[10]);
    endfunction
`endif

    always_comb begin
        step_sel = (state == STOP && estop) ? STEP4 : STEP1;
        aim_l    = (state == STOP) ? 11'sd0 : tgt_lft;
        aim_r    = (state == STOP) ? 11'sd0 : tgt_rght;
        cand_l   = slew(lft_spd, aim_l, step_sel);
        cand_r   = slew(rght_spd, aim_r, step_sel);
        lft_nxt  = cand_l;
        rght_nxt = cand_r;
`ifdef RAMP_ZERO_CROSS_HOLD_EN
        hold_l_nxt = hold_l;
        hold_r_nxt = hold_r;
        if (hold_l) begin
            lft_nxt    = '0;
            hold_l_nxt = 1'b0;
        end else if (crosses(lft_spd, cand_l)) begin
            lft_nxt    = '0;
            hold_l_nxt = 1'b1;
        end
        if (hold_r) begin
            rght_nxt   = '0;
            hold_r_nxt = 1'b0;
        end else if (crosses(rght_spd, cand_r)) begin
            rght_nxt   = '0;
            hold_r_nxt = 1'b1;
        end
`endif
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!estop && en) state_nxt = RAMP;
            end
            RAMP: begin
                if (estop || !en) state_nxt = STOP;
                else if (tick && lft_nxt == tgt_lft && rght_nxt == tgt_rght) state_nxt = SETTLED;
            end
            SETTLED: begin
                if (estop || !en) state_nxt = STOP;
                else if (lft_spd != tgt_lft || rght_spd != tgt_rght) state_nxt = RAMP;
            end
            STOP: begin
                if (!estop && lft_spd == '0 && rght_spd == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            settled  <= 1'b0;
            busy     <= 1'b0;
`ifdef RAMP_ZERO_CROSS_HOLD_EN
            hold_l   <= 1'b0;
            hold_r   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            settled <= (state_nxt == SETTLED);
            busy    <= (state_nxt == RAMP) || (state_nxt == STOP);
            if (state == IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + 16'd1;
            if (state == IDLE) begin
                lft_spd  <= '0;
                rght_spd <= '0;
`ifdef RAMP_ZERO_CROSS_HOLD_EN
                hold_l   <= 1'b0;
                hold_r   <= 1'b0;
`endif
            end else if (tick && (state == RAMP || state == STOP)) begin
                lft_spd  <= lft_nxt;
                rght_spd <= rght_nxt;
`ifdef RAMP_ZERO_CROSS_HOLD_EN
                hold_l   <= hold_l_nxt;
                hold_r   <= hold_r_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mtr_ramp.sv
// Directed bench for mtr_ramp (STEP=8, DIV=4): per-tick expected speeds are queued
// with the stimulus and compared at each tick sample.
module tb_mtr_ramp;

    localparam int STEP = 8;
    localparam int DIV  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               estop;
    logic signed [10:0] tgt_lft;
    logic signed [10:0] tgt_rght;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               settled;
    logic               busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int tick_ref = 0;
    logic [21:0] exp_q[$];

    mtr_ramp #(.STEP(STEP), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .estop(estop),
        .tgt_lft(tgt_lft), .tgt_rght(tgt_rght),
        .lft_spd(lft_spd), .rght_spd(rght_spd),
        .settled(settled), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push(input int l, input int r);
        logic [31:0] lv, rv;
        lv = l;
        rv = r;
        exp_q.push_back({lv[10:0], rv[10:0]});
    endtask

    // Tick edges are those congruent to tick_ref modulo DIV; sample on the following negedge.
    task automatic next_tick();
        do begin
            @(posedge clk);
            #1;
        end while (((cyc - tick_ref) % DIV) != 0);
        @(negedge clk);
    endtask

    task automatic drain();
        logic [21:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_tick();
            check("lft_spd", lft_spd, $signed(e[21:11]));
            check("rght_spd", rght_spd, $signed(e[10:0]));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; estop = 1'b0; tgt_lft = '0; tgt_rght = '0;
        repeat (2) @(negedge clk);
        check("rst_lft", lft_spd, 0);
        check("rst_rght", rght_spd, 0);
        check("rst_settled", settled, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // en with estop stays idle
        en = 1'b1; estop = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_estop_busy", busy, 0);
        check("idle_estop_lft", lft_spd, 0);
        en = 1'b0; estop = 1'b0;
        @(negedge clk);

        // basic ramp 100 / -40
        tgt_lft = 11'sd100; tgt_rght = -11'sd40; en = 1'b1;
        tick_ref = cyc + 1;
        @(negedge clk);
        check("ramp_busy", busy, 1);
        check("ramp_lft0", lft_spd, 0);
        for (int i = 1; i <= 12; i++) push(8 * i, (8 * i > 40) ? -40 : -8 * i);
        drain();
        check("pre_settle", settled, 0);
        push(100, -40);
        drain();
        check("settled_13", settled, 1);
        check("settled_busy", busy, 0);

        // en drop from SETTLED
        en = 1'b0;
        @(negedge clk);
        check("en_off_settled", settled, 0);
        check("en_off_busy", busy, 1);
        for (int i = 1; i <= 13; i++) push((100 - 8 * i < 0) ? 0 : 100 - 8 * i,
                                           (8 * i > 40) ? 0 : -40 + 8 * i);
        drain();
        @(negedge clk);
        check("stop_idle_busy", busy, 0);
        check("stop_idle_settled", settled, 0);

        // mid-ramp target change
        tgt_lft = 11'sd100; tgt_rght = '0; en = 1'b1;
        tick_ref = cyc + 1;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) push(8 * i, 0);
        drain();
        tgt_lft = 11'sd40;
        push(40, 0);
        drain();
        check("retarget_settled", settled, 1);

        // zero crossing 20 -> -20
        tgt_lft = 11'sd20;
        push(32, 0); push(24, 0); push(20, 0);
        drain();
        check("at20_settled", settled, 1);
        tgt_lft = -11'sd20;
`ifdef RAMP_ZERO_CROSS_HOLD_EN
        push(12, 0); push(4, 0); push(0, 0); push(0, 0);
        push(-8, 0); push(-16, 0); push(-20, 0);
`else
        push(12, 0); push(4, 0); push(-4, 0); push(-12, 0); push(-20, 0);
`endif
        drain();
        check("neg20_settled", settled, 1);

        // ramp to 200 then estop
        tgt_lft = 11'sd200;
        @(negedge clk);
        for (int i = 0; i < 400 && !settled; i++) @(negedge clk);
        check("settle_200_wait", settled, 1);
        check("at200_lft", lft_spd, 200);
        estop = 1'b1;
        @(negedge clk);
        check("estop_busy", busy, 1);
        check("estop_settled", settled, 0);
        for (int i = 1; i <= 7; i++) push((200 - 32 * i < 0) ? 0 : 200 - 32 * i, 0);
        drain();
        next_tick();
        check("estop_hold_lft", lft_spd, 0);
        check("estop_hold_busy", busy, 1);
        estop = 1'b0;
        tick_ref = cyc + 2;
        @(negedge clk);
        check("release_idle_busy", busy, 0);
        @(negedge clk);
        check("restart_busy", busy, 1);
        push(8, 0); push(16, 0);
        drain();

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_rst_lft", lft_spd, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_settled", settled, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_no_change", lft_spd, 0);
        @(negedge clk);
        check("post_rst_first", lft_spd, 8);
        check("post_rst_busy", busy, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
